// File: rtl/mod_addsub_seq.sv
// Modular add/subtract sequencer, (A +/- B) mod M, driving a shared external
// W-bit prefix adder one pass per cycle and applying the modulus correction.
//
// state | meaning
// IDLE  | waiting for a modulus load or a request
// NEGM  | adder computes ~M + 1, captured as negm = 2^W - M
// P1    | add: A + B -> S;   sub: A + ~B -> X
// P2    | add: S + negm, carry picks S or S - M;  sub: X + 1 -> Y, A>=B done
// P3    | sub with A<B: Y + M
// RESP  | result held until rsp_ready
module mod_addsub_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mod_load,
    input  logic [W-1:0] mod_in,
    output logic         mod_ok,
    output logic         mod_err,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_sub,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_res,
    output logic         rsp_wrap,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W:0]   add_sum
);

    typedef enum logic [2:0] {IDLE, NEGM, P1, P2, P3, RESP} state_t;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       state;
    logic [W-1:0] modReg;
    logic [W-1:0] negm;
    logic         subReg;
    logic [W-1:0] aReg;
    logic [W-1:0] bReg;
    logic [W:0]   sReg;
    logic [W-1:0] yReg;
    logic         geMod;

    assign req_ready = (state == IDLE) && mod_ok && !mod_load;

    // In P2 the same carry test serves both paths: add S>=M, sub A>=B.
    assign geMod = sReg[W] | add_sum[W];

    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            NEGM: begin
                add_a = ~modReg;
                add_b = ONE;
            end
            P1: begin
                add_a = aReg;
                add_b = subReg ? ~bReg : bReg;
            end
            P2: begin
                add_a = sReg[W-1:0];
                add_b = subReg ? ONE : negm;
            end
            P3: begin
                add_a = yReg;
                add_b = modReg;
            end
            default: begin
                add_a = '0;
                add_b = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            modReg    <= '0;
            negm      <= '0;
            subReg    <= 1'b0;
            aReg      <= '0;
            bReg      <= '0;
            sReg      <= '0;
            yReg      <= '0;
            mod_ok    <= 1'b0;
            mod_err   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_wrap  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mod_load) begin
                        // A new modulus invalidates negm until NEGM recomputes it.
                        mod_ok <= 1'b0;
                        if (mod_in[W-1:1] == '0) begin
                            mod_err <= 1'b1;
                        end else begin
                            modReg <= mod_in;
                            state  <= NEGM;
                        end
                    end else if (req_valid && mod_ok) begin
                        subReg <= req_sub;
                        aReg   <= req_a;
                        bReg   <= req_b;
                        state  <= P1;
                    end
                end
                NEGM: begin
                    negm    <= add_sum[W-1:0];
                    mod_ok  <= 1'b1;
                    mod_err <= 1'b0;
                    state   <= IDLE;
                end
                P1: begin
                    sReg  <= add_sum;
                    state <= P2;
                end
                P2: begin
                    yReg <= add_sum[W-1:0];
                    if (!subReg) begin
                        rsp_res   <= geMod ? add_sum[W-1:0] : sReg[W-1:0];
                        rsp_wrap  <= geMod;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (geMod) begin
                        rsp_res   <= add_sum[W-1:0];
                        rsp_wrap  <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        state <= P3;
                    end
                end
                P3: begin
                    rsp_res   <= add_sum[W-1:0];
                    rsp_wrap  <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Bench for mod_addsub_seq: plain-arithmetic reference model, an ideal adder
// on the add_a/add_b/add_sum ports, directed and randomized scenarios.
module tb_mod_addsub_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         mod_load;
    logic [W-1:0] mod_in;
    logic         mod_ok;
    logic         mod_err;
    logic         req_valid;
    logic         req_ready;
    logic         req_sub;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_res;
    logic         rsp_wrap;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W:0]   add_sum;

    int nAssert = 0;
    int nFail   = 0;

    mod_addsub_seq #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .mod_load(mod_load), .mod_in(mod_in), .mod_ok(mod_ok), .mod_err(mod_err),
        .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_wrap(rsp_wrap),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum)
    );

    // Ideal shared adder.
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;

    // Reference: (A +/- B) mod M with the wrap flag meaning "M was subtracted/added".
    function automatic void model(input int a, input int b, input bit sub, input int m,
                                  output logic [W-1:0] res, output logic wrap, output int lat);
        int r;
        if (!sub) begin
            r    = a + b;
            wrap = (r >= m);
            if (wrap) r = r - m;
            lat  = 2;
        end else begin
            r    = a - b;
            wrap = (r < 0);
            if (wrap) r = r + m;
            lat  = wrap ? 3 : 2;
        end
        res = r[W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mod(input logic [W-1:0] m);
        mod_load = 1'b1;
        mod_in   = m;
        tick();
        mod_load = 1'b0;
        tick();
    endtask

    // Issues one request and returns once rsp_valid is seen; lat counts edges after accept.
    task automatic issue_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                            output int lat, output bit timedOut);
        int waitCnt = 0;
        timedOut = 1'b0;
        while (!req_ready && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        if (!req_ready) timedOut = 1'b1;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        if (!rsp_valid) timedOut = 1'b1;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mod_load = 0; mod_in = 0; req_valid = 0; req_sub = 0;
        req_a = 0; req_b = 0; rsp_ready = 0;
        #1;
        nAssert++; if (mod_ok !== 1'b0) begin nFail++; $display("FAIL reset_mod_ok got %0b exp 0", mod_ok); end
        nAssert++; if (mod_err !== 1'b0) begin nFail++; $display("FAIL reset_mod_err got %0b exp 0", mod_err); end
        nAssert++; if (rsp_valid !== 1'b0) begin nFail++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
        nAssert++; if ({rsp_res, rsp_wrap} !== 5'd0) begin nFail++; $display("FAIL reset_rsp got %0d/%0b exp 0/0", rsp_res, rsp_wrap); end
        nAssert++; if ({add_a, add_b} !== 8'd0) begin nFail++; $display("FAIL reset_adder got %0d,%0d exp 0,0", add_a, add_b); end
        tick(); tick();
        rst = 1'b0;
        tick();
        nAssert++; if (req_ready !== 1'b0) begin nFail++; $display("FAIL reset_req_ready got %0b exp 0", req_ready); end
    endtask

    task automatic test_mod_load();
        mod_load = 1'b1;
        mod_in   = 4'd11;
        tick();
        mod_load = 1'b0;
        // One cycle in NEGM: adder sees (~11, 1) = (4, 1).
        nAssert++; if (add_a !== 4'd4 || add_b !== 4'd1) begin nFail++; $display("FAIL negm_operands got %0d,%0d exp 4,1", add_a, add_b); end
        nAssert++; if (mod_ok !== 1'b0) begin nFail++; $display("FAIL negm_mod_ok_early got %0b exp 0", mod_ok); end
        tick();
        nAssert++; if (mod_ok !== 1'b1 || mod_err !== 1'b0) begin nFail++; $display("FAIL load_mod_ok got ok=%0b err=%0b exp 1,0", mod_ok, mod_err); end
        nAssert++; if (req_ready !== 1'b1) begin nFail++; $display("FAIL load_req_ready got %0b exp 1", req_ready); end
        nAssert++; if ({add_a, add_b} !== 8'd0) begin nFail++; $display("FAIL idle_adder got %0d,%0d exp 0,0", add_a, add_b); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [6] = '{4'd7, 4'd3, 4'd10, 4'd9, 4'd4, 4'd0};
        logic [W-1:0] vb [6] = '{4'd6, 4'd4, 4'd10, 4'd4, 4'd9, 4'd0};
        bit           vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] er [6] = '{4'd2, 4'd7, 4'd9, 4'd5, 4'd6, 4'd0};
        logic         ew [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int           el [6] = '{2, 2, 2, 2, 3, 2};
        int lat;
        bit to;
        for (int i = 0; i < 6; i++) begin
            issue_op(va[i], vb[i], vs[i], lat, to);
            nAssert++; if (to) begin nFail++; $display("FAIL dir%0d_timeout got timeout exp response", i); end
            nAssert++; if (rsp_res !== er[i] || rsp_wrap !== ew[i]) begin nFail++; $display("FAIL dir%0d_result got %0d/%0b exp %0d/%0b", i, rsp_res, rsp_wrap, er[i], ew[i]); end
            nAssert++; if (lat !== el[i]) begin nFail++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, el[i]); end
            ack_rsp();
            nAssert++; if (rsp_valid !== 1'b0) begin nFail++; $display("FAIL dir%0d_rsp_drop got %0b exp 0", i, rsp_valid); end
        end
    endtask

    task automatic test_mod_err();
        load_mod(4'd1);
        nAssert++; if (mod_err !== 1'b1 || mod_ok !== 1'b0) begin nFail++; $display("FAIL bad_mod got err=%0b ok=%0b exp 1,0", mod_err, mod_ok); end
        nAssert++; if (req_ready !== 1'b0) begin nFail++; $display("FAIL bad_mod_req_ready got %0b exp 0", req_ready); end
        load_mod(4'd0);
        nAssert++; if (mod_err !== 1'b1) begin nFail++; $display("FAIL bad_mod0 got err=%0b exp 1", mod_err); end
        load_mod(4'd11);
        nAssert++; if (mod_err !== 1'b0 || mod_ok !== 1'b1) begin nFail++; $display("FAIL reload got err=%0b ok=%0b exp 0,1", mod_err, mod_ok); end
    endtask

    task automatic test_load_priority();
        int lat;
        bit to;
        mod_load  = 1'b1;
        mod_in    = 4'd13;
        req_valid = 1'b1;
        req_a = 4'd1; req_b = 4'd2; req_sub = 1'b0;
        #1;
        nAssert++; if (req_ready !== 1'b0) begin nFail++; $display("FAIL prio_req_ready got %0b exp 0", req_ready); end
        tick();
        mod_load  = 1'b0;
        req_valid = 1'b0;
        // Load won: NEGM for 13 drives (2, 1), not the request operands.
        nAssert++; if (add_a !== 4'd2 || add_b !== 4'd1) begin nFail++; $display("FAIL prio_negm got %0d,%0d exp 2,1", add_a, add_b); end
        tick();
        nAssert++; if (rsp_valid !== 1'b0 || mod_ok !== 1'b1) begin nFail++; $display("FAIL prio_state got valid=%0b ok=%0b exp 0,1", rsp_valid, mod_ok); end
        issue_op(4'd12, 4'd5, 1'b0, lat, to);
        nAssert++; if (to || rsp_res !== 4'd4 || rsp_wrap !== 1'b1) begin nFail++; $display("FAIL prio_m13_add got %0d/%0b to=%0b exp 4/1", rsp_res, rsp_wrap, to); end
        ack_rsp();
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        issue_op(4'd2, 4'd9, 1'b1, lat, to);   // M=13: 2-9+13 = 6
        nAssert++; if (to || lat !== 3) begin nFail++; $display("FAIL bp_latency got %0d to=%0b exp 3", lat, to); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                mod_load = 1'b1;
                mod_in   = 4'd1;
            end
            tick();
            mod_load = 1'b0;
            nAssert++; if (rsp_valid !== 1'b1 || rsp_res !== 4'd6 || rsp_wrap !== 1'b1) begin nFail++; $display("FAIL bp_hold%0d got v=%0b %0d/%0b exp 1 6/1", i, rsp_valid, rsp_res, rsp_wrap); end
            nAssert++; if (req_ready !== 1'b0) begin nFail++; $display("FAIL bp_req_ready%0d got %0b exp 0", i, req_ready); end
        end
        ack_rsp();
        nAssert++; if (mod_err !== 1'b0 || mod_ok !== 1'b1) begin nFail++; $display("FAIL bp_load_ignored got err=%0b ok=%0b exp 0,1", mod_err, mod_ok); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] er;
        logic         ew;
        int el, lat;
        bit to;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] a = W'($urandom_range(0, 12));
            logic [W-1:0] b = W'($urandom_range(0, 12));
            bit s = 1'($urandom_range(0, 1));
            model(int'(a), int'(b), s, 13, er, ew, el);
            issue_op(a, b, s, lat, to);
            nAssert++; if (to || rsp_res !== er || rsp_wrap !== ew || lat !== el) begin nFail++; $display("FAIL b2b%0d got %0d/%0b lat %0d exp %0d/%0b lat %0d", i, rsp_res, rsp_wrap, lat, er, ew, el); end
            tick();
            nAssert++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin nFail++; $display("FAIL b2b%0d_release got v=%0b rdy=%0b exp 0,1", i, rsp_valid, req_ready); end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] er;
        logic         ew;
        int el, lat, m;
        bit to;
        for (int r = 0; r < 4; r++) begin
            m = $urandom_range(2, 15);
            load_mod(W'(m));
            for (int i = 0; i < 25; i++) begin
                int a = $urandom_range(0, m - 1);
                int b = $urandom_range(0, m - 1);
                bit s = 1'($urandom_range(0, 1));
                model(a, b, s, m, er, ew, el);
                issue_op(W'(a), W'(b), s, lat, to);
                nAssert++; if (to || rsp_res !== er || rsp_wrap !== ew || lat !== el) begin nFail++; $display("FAIL rand m=%0d %0d%s%0d got %0d/%0b lat %0d exp %0d/%0b lat %0d", m, a, s ? "-" : "+", b, rsp_res, rsp_wrap, lat, er, ew, el); end
                repeat ($urandom_range(0, 2)) tick();
                ack_rsp();
            end
        end
    endtask

    task automatic test_reset_midpass();
        int waitCnt = 0;
        bit sawRsp = 1'b0;
        while (!req_ready && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        req_valid = 1'b1;
        req_a = 4'd1; req_b = 4'd3; req_sub = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();                 // now in P2
        rst = 1'b1;
        #1;
        nAssert++; if (rsp_valid !== 1'b0 || mod_ok !== 1'b0) begin nFail++; $display("FAIL midrst got v=%0b ok=%0b exp 0,0", rsp_valid, mod_ok); end
        nAssert++; if ({add_a, add_b} !== 8'd0) begin nFail++; $display("FAIL midrst_adder got %0d,%0d exp 0,0", add_a, add_b); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid) sawRsp = 1'b1;
        end
        nAssert++; if (sawRsp || req_ready !== 1'b0) begin nFail++; $display("FAIL midrst_after got rsp=%0b rdy=%0b exp 0,0", sawRsp, req_ready); end
    endtask

    initial begin
        test_reset();
        test_mod_load();
        test_directed();
        test_mod_err();
        test_load_priority();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midpass();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
